// File: rtl/kbd_buffer.sv
// Scancode buffer between the PS/2 receiver and the port controller.
// Edge-detects received bytes, folds set-2 break prefixes (F0 xx -> xx|80),
// queues bytes in a small FIFO and presents the head byte with a one-cycle
// IRQ1 pulse each time a new byte becomes the head.
module kbd_buffer #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter bit FOLD_BREAK = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [7:0]        kb_data,
  input  logic              kb_hit,
  input  logic              rd,
  input  logic              flush,
  output logic [7:0]        q,
  output logic              ready,
  output logic              irq,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_CNT  = (ADDR_W + 1)'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_inc;
  logic              hit_d;
  logic              brk;

  logic              cap;
  logic              is_prefix;
  logic              store;
  logic [7:0]        push_byte;
  logic              empty;
  logic              full;
  logic              popping;
  logic              pushing;
  logic              drop;
  logic              head_from_push;

  assign ready = (count != '0);

  // Capture decode: byte edge, prefix folding and push/pop qualification.
  always_comb begin
    rd_ptr_inc     = rd_ptr + 1'b1;
    cap            = kb_hit & ~hit_d;
    is_prefix      = FOLD_BREAK && (kb_data == 8'hF0);
    // Only bytes below 80 get the break bit; E0/E1/FA/FE etc. pass raw.
    push_byte      = (FOLD_BREAK && brk && !kb_data[7]) ? (kb_data | 8'h80) : kb_data;
    store          = cap & ~is_prefix;
    empty          = (count == '0);
    full           = (count == FULL_CNT);
    // Flush overrides everything; a pop on an empty FIFO is ignored.
    popping        = rd & ~empty & ~flush;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    pushing        = store & (~full | popping) & ~flush;
    drop           = store & full & ~popping & ~flush;
    // Pushed byte becomes head directly if the FIFO is (or is becoming) empty.
    head_from_push = pushing & (empty | (popping & (count == ONE_CNT)));
  end

  // FIFO storage: write-only here, no reset so it maps onto RAM.
  always_ff @(posedge clock) begin
    if (pushing) mem[wr_ptr] <= push_byte;
  end

  // Control state: edge register, prefix flag, pointers, count, head register, flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hit_d    <= 1'b1;
      brk      <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      q        <= 8'h00;
      irq      <= 1'b0;
      overflow <= 1'b0;
    end else begin
      hit_d <= kb_hit;
      irq   <= 1'b0;
      if (flush) begin
        brk      <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        // Every captured byte consumes the prefix, even when it is dropped.
        if (cap) brk <= is_prefix;
        if (pushing) wr_ptr <= wr_ptr + 1'b1;
        if (popping) rd_ptr <= rd_ptr_inc;
        if (pushing && !popping)      count <= count + 1'b1;
        else if (popping && !pushing) count <= count - 1'b1;
        if (drop) overflow <= 1'b1;
        if (head_from_push) begin
          q   <= push_byte;
          irq <= 1'b1;
        end else if (popping && (count > ONE_CNT)) begin
          q   <= mem[rd_ptr_inc];
          irq <= 1'b1;
        end
      end
    end
  end

endmodule
